// File: rtl/seg_scan_ctrl_if.sv
// Display-side bus of the seven-segment scan controller.
// The upstream data source uses the master side, and the scan controller uses the slave side.
interface seg_scan_ctrl_if #(
   parameter int NUM_DIGITS = 4
);
   logic                    load;
   logic [4*NUM_DIGITS-1:0] data_in;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic                    lz_en;
   logic [3:0]              digit_code;
   logic                    dp_n;
   logic [NUM_DIGITS-1:0]   an_n;
   logic                    frame_done;
   logic                    load_pending;

   modport master (
      output load, data_in, dp_in, lz_en,
      input  digit_code, dp_n, an_n, frame_done, load_pending
   );

   modport slave (
      input  load, data_in, dp_in, lz_en,
      output digit_code, dp_n, an_n, frame_done, load_pending
   );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// A shadow buffer collects new data and hands it to the active buffer only at a
// frame boundary, so a frame never shows a mix of old and new data. Every output
// is registered from the next counter state, so it lines up with cnt/idx.
module seg_scan_ctrl #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic           clk,
   input  logic           rst_n,
   seg_scan_ctrl_if.slave bus
);

   localparam int CNT_W = $clog2(REFRESH_DIV);
   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam logic [3:0]       CODE_OFF = 4'hA;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   logic [CNT_W-1:0]        slotCnt_q, slotCnt_d;
   logic [IDX_W-1:0]        digitIdx_q, digitIdx_d;
   logic [4*NUM_DIGITS-1:0] activeCode_q, activeCode_d;
   logic [4*NUM_DIGITS-1:0] shadowCode_q, shadowCode_d;
   logic [NUM_DIGITS-1:0]   activeDp_q, activeDp_d;
   logic [NUM_DIGITS-1:0]   shadowDp_q, shadowDp_d;
   logic                    loadPending_q, loadPending_d;
   logic [NUM_DIGITS-1:0]   anN_q, anN_d;
   logic [3:0]              digitCode_q, digitCode_d;
   logic                    dpN_q, dpN_d;
   logic                    frameDone_q, frameDone_d;

   logic                    slotEnd;
   logic                    frameEnd;
   logic                    suppress;
   logic                    inBlank;
   logic [4*NUM_DIGITS-1:0] effCode;

   // State register: scan position, both data buffers, and the registered display outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slotCnt_q     <= '0;
         digitIdx_q    <= '0;
         activeCode_q  <= {NUM_DIGITS{CODE_OFF}};
         shadowCode_q  <= {NUM_DIGITS{CODE_OFF}};
         activeDp_q    <= '0;
         shadowDp_q    <= '0;
         loadPending_q <= 1'b0;
         anN_q         <= '1;
         digitCode_q   <= CODE_OFF;
         dpN_q         <= 1'b1;
         frameDone_q   <= 1'b0;
      end else begin
         slotCnt_q     <= slotCnt_d;
         digitIdx_q    <= digitIdx_d;
         activeCode_q  <= activeCode_d;
         shadowCode_q  <= shadowCode_d;
         activeDp_q    <= activeDp_d;
         shadowDp_q    <= shadowDp_d;
         loadPending_q <= loadPending_d;
         anN_q         <= anN_d;
         digitCode_q   <= digitCode_d;
         dpN_q         <= dpN_d;
         frameDone_q   <= frameDone_d;
      end
   end

   // Next state: advance the slot/digit counters and move data between the buffers.
   // A load on the boundary cycle goes straight to the active buffer, so the new
   // frame shows the new data and no pending flag is left behind.
   always_comb begin
      slotEnd       = (slotCnt_q == CNT_LAST);
      frameEnd      = slotEnd && (digitIdx_q == IDX_LAST);
      slotCnt_d     = slotEnd ? '0 : slotCnt_q + CNT_W'(1);
      digitIdx_d    = digitIdx_q;
      activeCode_d  = activeCode_q;
      shadowCode_d  = shadowCode_q;
      activeDp_d    = activeDp_q;
      shadowDp_d    = shadowDp_q;
      loadPending_d = loadPending_q;

      if (slotEnd) begin
         digitIdx_d = frameEnd ? '0 : digitIdx_q + IDX_W'(1);
      end

      if (frameEnd) begin
         if (bus.load) begin
            activeCode_d  = bus.data_in;
            activeDp_d    = bus.dp_in;
            shadowCode_d  = bus.data_in;
            shadowDp_d    = bus.dp_in;
            loadPending_d = 1'b0;
         end else if (loadPending_q) begin
            activeCode_d  = shadowCode_q;
            activeDp_d    = shadowDp_q;
            loadPending_d = 1'b0;
         end
      end else if (bus.load) begin
         shadowCode_d  = bus.data_in;
         shadowDp_d    = bus.dp_in;
         loadPending_d = 1'b1;
      end
   end

   // Output decode: apply leading-zero suppression from the top digit down, then
   // select the anode, code and decimal point for the upcoming counter position.
   always_comb begin
      effCode  = activeCode_d;
      suppress = bus.lz_en;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         if (suppress && (activeCode_d[4*i +: 4] == 4'h0)) begin
            effCode[4*i +: 4] = CODE_OFF;
         end else begin
            suppress = 1'b0;
         end
      end

      inBlank     = int'(slotCnt_d) < BLANK_CYCLES;
      anN_d       = '1;
      digitCode_d = CODE_OFF;
      dpN_d       = 1'b1;
      frameDone_d = frameEnd;

      if (!inBlank) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digitIdx_d == IDX_W'(i)) begin
               anN_d[i]    = 1'b0;
               digitCode_d = effCode[4*i +: 4];
               dpN_d       = ~activeDp_d[i];
            end
         end
      end
   end

   assign bus.an_n         = anN_q;
   assign bus.digit_code   = digitCode_q;
   assign bus.dp_n         = dpN_q;
   assign bus.frame_done   = frameDone_q;
   assign bus.load_pending = loadPending_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl with 4 digits, 8-cycle slots and 2 blank cycles.
// A free-running cycle counter gives the expected scan position. A small display
// model gives the expected anode, code, decimal point, strobe and pending flag.
module tb_seg_scan_ctrl;

   localparam int ND    = 4;
   localparam int RD    = 8;
   localparam int BC    = 2;
   localparam int FRAME = ND * RD;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;
   int   testsRun    = 0;
   int   testsFailed = 0;

   logic [15:0] shownData, nextData;
   logic [3:0]  shownDp, nextDp;
   logic        pendExp, lzExp;
   logic [10:0] expVec;

   seg_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

   seg_scan_ctrl #(
      .NUM_DIGITS  (ND),
      .REFRESH_DIV (RD),
      .BLANK_CYCLES(BC)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   // Free-running clock with a 10-time-unit period.
   always #5 clk = ~clk;

   // Count cycles since reset release. This count is the expected scan position.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   // Expected {an_n, digit_code, dp_n, frame_done, load_pending} at a cycle count.
   function automatic logic [10:0] expOut(input int c, input logic [15:0] data,
                                          input logic [3:0] dp, input logic lz, input logic pend);
      int         slot = c % RD;
      int         d    = (c / RD) % ND;
      int         msd  = 0;
      logic [3:0] code;
      logic [3:0] an;
      logic       fd   = (c % FRAME == 0) && (c != 0);
      for (int k = 0; k < ND; k++) if (data[4*k +: 4] != 4'h0) msd = k;
      if (slot < BC) return {4'hF, 4'hA, 1'b1, fd, pend};
      code = data[4*d +: 4];
      if (lz && d > msd) code = 4'hA;
      an = ~(4'b0001 << d);
      return {an, code, ~dp[d], fd, pend};
   endfunction

   // Advance one clock and apply any pending buffer swap on a frame boundary.
   task automatic stepModel();
      @(posedge clk); #1;
      if ((cyc % FRAME == 0) && pendExp) begin
         shownData = nextData;
         shownDp   = nextDp;
         pendExp   = 1'b0;
      end
   endtask

   // Advance the clock until the scan reaches a given position in the frame.
   task automatic alignTo(input int pos);
      for (int k = 0; k < FRAME && (cyc % FRAME) != pos; k++) stepModel();
   endtask

   // Pulse load for one edge and record where the data is expected to go.
   task automatic driveLoad(input logic [15:0] d, input logic [3:0] p);
      bus.data_in = d;
      bus.dp_in   = p;
      bus.load    = 1'b1;
      @(posedge clk); #1;
      bus.load = 1'b0;
      if (cyc % FRAME == 0) begin
         shownData = d; shownDp = p; pendExp = 1'b0;
      end else begin
         nextData = d; nextDp = p; pendExp = 1'b1;
      end
   endtask

   // Hold reset, check the idle output values, then release reset away from the clock edge.
   task automatic test_reset();
      bus.load = 1'b0; bus.data_in = '0; bus.dp_in = '0; bus.lz_en = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      testsRun++; if (bus.an_n !== 4'hF) begin testsFailed++; $display("[TB] FAIL reset_an_n got=%h expected=%h", bus.an_n, 4'hF); end
      testsRun++; if (bus.digit_code !== 4'hA) begin testsFailed++; $display("[TB] FAIL reset_code got=%h expected=%h", bus.digit_code, 4'hA); end
      testsRun++; if (bus.dp_n !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_dp_n got=%b expected=1", bus.dp_n); end
      testsRun++; if (bus.frame_done !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_frame_done got=%b expected=0", bus.frame_done); end
      testsRun++; if (bus.load_pending !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_pending got=%b expected=0", bus.load_pending); end
      shownData = 16'hAAAA; shownDp = 4'h0; nextData = 16'hAAAA; nextDp = 4'h0;
      pendExp = 1'b0; lzExp = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // With no data loaded, scan two frames and check blanking, rotation and the frame strobe.
   task automatic test_blank_scan();
      for (int k = 0; k < 2 * FRAME; k++) begin
         stepModel();
         expVec = expOut(cyc, shownData, shownDp, lzExp, pendExp);
         testsRun++;
         if ({bus.an_n, bus.digit_code, bus.dp_n, bus.frame_done, bus.load_pending} !== expVec) begin
            testsFailed++;
            $display("[TB] FAIL blank_scan cyc=%0d got=%h expected=%h", cyc,
                     {bus.an_n, bus.digit_code, bus.dp_n, bus.frame_done, bus.load_pending}, expVec);
         end
      end
   endtask

   // Load 1234 with a decimal point on digit 2 in mid-frame. The data stays pending until the boundary.
   task automatic test_load();
      alignTo(10);
      driveLoad(16'h1234, 4'b0100);
      for (int k = 0; k < 21 + FRAME; k++) begin
         stepModel();
         expVec = expOut(cyc, shownData, shownDp, lzExp, pendExp);
         testsRun++;
         if ({bus.an_n, bus.digit_code, bus.dp_n, bus.frame_done, bus.load_pending} !== expVec) begin
            testsFailed++;
            $display("[TB] FAIL load cyc=%0d got=%h expected=%h", cyc,
                     {bus.an_n, bus.digit_code, bus.dp_n, bus.frame_done, bus.load_pending}, expVec);
         end
      end
   endtask

   // Check leading-zero suppression on 0040 and 0000 (with decimal points), then turn suppression off live.
   task automatic test_lz();
      bus.lz_en = 1'b1; lzExp = 1'b1;
      for (int pass = 0; pass < 3; pass++) begin
         if (pass == 0) driveLoad(16'h0040, 4'b0000);
         if (pass == 1) driveLoad(16'h0000, 4'b1001);
         if (pass == 2) begin bus.lz_en = 1'b0; lzExp = 1'b0; end
         for (int k = 0; k < ((pass == 2) ? 16 : FRAME - 1 + FRAME); k++) begin
            stepModel();
            expVec = expOut(cyc, shownData, shownDp, lzExp, pendExp);
            testsRun++;
            if ({bus.an_n, bus.digit_code, bus.dp_n, bus.frame_done, bus.load_pending} !== expVec) begin
               testsFailed++;
               $display("[TB] FAIL lz_pass%0d cyc=%0d got=%h expected=%h", pass, cyc,
                        {bus.an_n, bus.digit_code, bus.dp_n, bus.frame_done, bus.load_pending}, expVec);
            end
         end
      end
   endtask

   // Load twice in one frame. Only the second value may appear on the display.
   task automatic test_back_to_back();
      alignTo(5);
      driveLoad(16'h1111, 4'b0000);
      for (int pass = 0; pass < 2; pass++) begin
         if (pass == 1) driveLoad(16'h2222, 4'b0000);
         for (int k = 0; k < ((pass == 0) ? 9 : 16 + FRAME); k++) begin
            stepModel();
            expVec = expOut(cyc, shownData, shownDp, lzExp, pendExp);
            testsRun++;
            if ({bus.an_n, bus.digit_code, bus.dp_n, bus.frame_done, bus.load_pending} !== expVec) begin
               testsFailed++;
               $display("[TB] FAIL back_to_back cyc=%0d got=%h expected=%h", cyc,
                        {bus.an_n, bus.digit_code, bus.dp_n, bus.frame_done, bus.load_pending}, expVec);
            end
         end
      end
   endtask

   // Load exactly on the boundary cycle. The new frame shows the data at once, with no pending flag.
   task automatic test_boundary_load();
      alignTo(FRAME - 1);
      driveLoad(16'h9876, 4'b0100);
      testsRun++;
      if ({bus.frame_done, bus.load_pending} !== 2'b10) begin
         testsFailed++;
         $display("[TB] FAIL boundary_load_flags got=%b expected=10", {bus.frame_done, bus.load_pending});
      end
      for (int k = 0; k < FRAME; k++) begin
         stepModel();
         expVec = expOut(cyc, 16'h9876, 4'b0100, lzExp, 1'b0);
         testsRun++;
         if ({bus.an_n, bus.digit_code, bus.dp_n, bus.frame_done, bus.load_pending} !== expVec) begin
            testsFailed++;
            $display("[TB] FAIL boundary_load cyc=%0d got=%h expected=%h", cyc,
                     {bus.an_n, bus.digit_code, bus.dp_n, bus.frame_done, bus.load_pending}, expVec);
         end
      end
   endtask

   // Reset in the idx=2 slot while data is pending. The outputs blank without waiting for a
   // clock edge. After release the scan restarts and the pending data is gone.
   task automatic test_reset_mid_slot();
      alignTo(16);
      driveLoad(16'h5555, 4'b0000);
      for (int k = 0; k < 3; k++) begin
         stepModel();
         expVec = expOut(cyc, shownData, shownDp, lzExp, pendExp);
         testsRun++;
         if ({bus.an_n, bus.digit_code, bus.dp_n, bus.frame_done, bus.load_pending} !== expVec) begin
            testsFailed++;
            $display("[TB] FAIL pre_reset cyc=%0d got=%h expected=%h", cyc,
                     {bus.an_n, bus.digit_code, bus.dp_n, bus.frame_done, bus.load_pending}, expVec);
         end
      end
      #3 rst_n = 1'b0;
      #1;
      testsRun++; if (bus.an_n !== 4'hF) begin testsFailed++; $display("[TB] FAIL async_an_n got=%h expected=%h", bus.an_n, 4'hF); end
      testsRun++; if (bus.digit_code !== 4'hA) begin testsFailed++; $display("[TB] FAIL async_code got=%h expected=%h", bus.digit_code, 4'hA); end
      testsRun++; if (bus.dp_n !== 1'b1) begin testsFailed++; $display("[TB] FAIL async_dp_n got=%b expected=1", bus.dp_n); end
      testsRun++; if (bus.load_pending !== 1'b0) begin testsFailed++; $display("[TB] FAIL async_pending got=%b expected=0", bus.load_pending); end
      shownData = 16'hAAAA; shownDp = 4'h0; pendExp = 1'b0;
      @(posedge clk);
      #4 rst_n = 1'b1;
      for (int k = 0; k < FRAME + 8; k++) begin
         stepModel();
         expVec = expOut(cyc, shownData, shownDp, lzExp, pendExp);
         testsRun++;
         if ({bus.an_n, bus.digit_code, bus.dp_n, bus.frame_done, bus.load_pending} !== expVec) begin
            testsFailed++;
            $display("[TB] FAIL post_reset cyc=%0d got=%h expected=%h", cyc,
                     {bus.an_n, bus.digit_code, bus.dp_n, bus.frame_done, bus.load_pending}, expVec);
         end
      end
   endtask

   // Run every scenario in order, then print the summary.
   initial begin
      test_reset();
      test_blank_scan();
      test_load();
      test_lz();
      test_back_to_back();
      test_boundary_load();
      test_reset_mid_slot();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
